// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter and sequencer that puts two requesters (A, B) onto one
// single-port synchronous RAM, one write or one registered read at a time.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A command, held until a_gnt
//   a_gnt                 one-cycle pulse when A's command is on the RAM port
//   a_rdata/a_rvalid      A read return, a_rvalid pulses for one cycle
//   b_*                   same set for requester B
//   ram_en/ram_we/ram_addr/ram_wdata  RAM command port
//   ram_rdata             RAM read data, valid the cycle after a read strobe
//   busy                  high whenever an operation is in progress
module single_port_ram_arbiter #(
    parameter int data_width = 8,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [data_width-1:0] a_rdata,
    output logic                  a_rvalid,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [data_width-1:0] b_rdata,
    output logic                  b_rvalid,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_wdata,
    input  logic [data_width-1:0] ram_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_b;
    logic owner_b;
    logic cmd_we;
    logic sel;
    logic pick_b;

    // B wins only if A is absent or A was served last.
    always_comb begin
        sel    = a_req | b_req;
        pick_b = b_req & (~a_req | ~last_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sel) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = cmd_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The command is captured straight into the RAM port registers, so the
    // RAM never sees a combinational path from the requesters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            cmd_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (state == IDLE && sel) begin
            last_b    <= pick_b;
            owner_b   <= pick_b;
            cmd_we    <= pick_b ? b_we : a_we;
            ram_addr  <= pick_b ? b_addr : a_addr;
            ram_wdata <= pick_b ? b_wdata : a_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= (state == RDWAIT) & ~owner_b;
            b_rvalid <= (state == RDWAIT) & owner_b;
            if (state == RDWAIT && !owner_b) begin
                a_rdata <= ram_rdata;
            end
            if (state == RDWAIT && owner_b) begin
                b_rdata <= ram_rdata;
            end
        end
    end

    assign ram_en = (state == ACCESS);
    assign ram_we = ram_en & cmd_we;
    assign a_gnt  = ram_en & ~owner_b;
    assign b_gnt  = ram_en & owner_b;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: timeline model plus directed tests.
// Includes a registered single-port RAM model on the DUT's RAM port.
module tb_single_port_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          preload = 1'b0;

    logic          a_req = 1'b0;
    logic          a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_gnt;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;

    logic          b_req = 1'b0;
    logic          b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    single_port_ram_arbiter #(
        .data_width(DW),
        .addr_width(AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pre_val(input int i);
        if (i < 4) begin
            return 8'(16 + i);
        end
        return 8'h00;
    endfunction

    // RAM: write on strobe, registered read data.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= pre_val(i);
            end
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Model: an operation started in cycle op_s occupies the port in
    // op_s, reads return in op_s+2, and the next decision may be taken
    // at the end of the first idle cycle (free).
    logic [7:0] m_mem [0:255];
    int         cyc;
    int         free;
    int         op_s;
    bit         op_rd;
    bit         op_b;
    bit         last_b;
    bit         m_pb;
    bit         m_we;
    logic [7:0] op_data;
    logic [7:0] m_a_rd;
    logic [7:0] m_b_rd;
    logic [7:0] e_addr;
    logic [7:0] e_wdata;
    bit e_a_gnt, e_b_gnt, e_en, e_we, e_busy, e_a_rv, e_b_rv;

    task m_reset;
        cyc = 0;
        free = 0;
        op_s = -10;
        op_rd = 0;
        op_b = 0;
        last_b = 1;
        m_a_rd = '0;
        m_b_rd = '0;
        e_addr = '0;
        e_wdata = '0;
        e_a_gnt = 0;
        e_b_gnt = 0;
        e_en = 0;
        e_we = 0;
        e_busy = 0;
        e_a_rv = 0;
        e_b_rv = 0;
    endtask

    task m_step;
        cyc++;
        e_a_rv = 0;
        e_b_rv = 0;
        if (op_rd && cyc == op_s + 2) begin
            if (op_b) begin
                e_b_rv = 1;
                m_b_rd = op_data;
            end else begin
                e_a_rv = 1;
                m_a_rd = op_data;
            end
        end
        if (cyc - 1 >= free && (a_req || b_req)) begin
            m_pb = b_req && (!a_req || !last_b);
            m_we = m_pb ? b_we : a_we;
            e_addr = m_pb ? b_addr : a_addr;
            e_wdata = m_pb ? b_wdata : a_wdata;
            op_s = cyc;
            op_b = m_pb;
            op_rd = !m_we;
            last_b = m_pb;
            if (m_we) begin
                m_mem[e_addr] = e_wdata;
                free = cyc + 1;
            end else begin
                op_data = m_mem[e_addr];
                free = cyc + 2;
            end
        end
        e_en = (cyc == op_s);
        e_we = e_en && !op_rd;
        e_a_gnt = e_en && !op_b;
        e_b_gnt = e_en && op_b;
        e_busy = (cyc >= op_s) && (cyc < free);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (preload) begin
                for (int i = 0; i < 256; i++) begin
                    m_mem[i] = pre_val(i);
                end
            end
            if (reset) begin
                m_reset();
            end else begin
                m_step();
            end
        end
    end

    // Compare every cycle and log events for the directed checks.
    int         tcyc = 0;
    logic [15:0] ord = '0;
    int         n_ord = 0;
    int         a_gnt_n = 0;
    int         a_rv_n = 0;
    logic [7:0] bq [$];
    int         bgc [$];

    initial begin
        forever begin
            @(negedge clk);
            tcyc++;
            chk("a_gnt", a_gnt, e_a_gnt);
            chk("b_gnt", b_gnt, e_b_gnt);
            chk("ram_en", ram_en, e_en);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
            chk("busy", busy, e_busy);
            chk("a_rvalid", a_rvalid, e_a_rv);
            chk("b_rvalid", b_rvalid, e_b_rv);
            chk("a_rdata", a_rdata, m_a_rd);
            chk("b_rdata", b_rdata, m_b_rd);
            if (a_gnt) begin
                ord = {ord[14:0], 1'b0};
                n_ord++;
                a_gnt_n++;
            end
            if (b_gnt) begin
                ord = {ord[14:0], 1'b1};
                n_ord++;
                bgc.push_back(tcyc);
            end
            if (a_rvalid) begin
                a_rv_n++;
            end
            if (b_rvalid) begin
                bq.push_back(b_rdata);
            end
        end
    end

    task automatic issue_a(input bit we, input logic [7:0] ad,
                           input logic [7:0] wd);
        int n;
        n = 0;
        a_req = 1'b1;
        a_we = we;
        a_addr = ad;
        a_wdata = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!a_gnt && n < 20);
        if (!a_gnt) begin
            chk("a_gnt_timeout", a_gnt, 1);
        end
        a_req = 1'b0;
    endtask

    task automatic issue_b(input bit we, input logic [7:0] ad,
                           input logic [7:0] wd);
        int n;
        n = 0;
        b_req = 1'b1;
        b_we = we;
        b_addr = ad;
        b_wdata = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!b_gnt && n < 20);
        if (!b_gnt) begin
            chk("b_gnt_timeout", b_gnt, 1);
        end
        b_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    int a_before;

    initial begin
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // A writes 04 to addr 2.
        a_req = 1'b1;
        a_we = 1'b1;
        a_addr = 8'd2;
        a_wdata = 8'h04;
        @(negedge clk);
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_ram_en", ram_en, 1);
        chk("t1_ram_we", ram_we, 1);
        chk("t1_ram_addr", ram_addr, 2);
        chk("t1_ram_wdata", ram_wdata, 8'h04);
        chk("t1_busy", busy, 1);
        a_req = 1'b0;
        @(negedge clk);

        // A reads addr 2.
        a_req = 1'b1;
        a_we = 1'b0;
        @(negedge clk);
        chk("t2_a_gnt", a_gnt, 1);
        chk("t2_ram_we", ram_we, 0);
        a_req = 1'b0;
        @(negedge clk);
        chk("t2_busy_rdwait", busy, 1);
        chk("t2_early_rvalid", a_rvalid, 0);
        @(negedge clk);
        chk("t2_a_rvalid", a_rvalid, 1);
        chk("t2_a_rdata", a_rdata, 8'h04);
        chk("t2_b_rvalid", b_rvalid, 0);

        // Tie after reset, then both continuously requesting.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_ord = 0;
        ord = '0;
        bq.delete();
        fork
            issue_a(1'b1, 8'd5, 8'hAA);
            issue_b(1'b0, 8'd5, 8'h00);
        join
        fork
            begin
                issue_a(1'b1, 8'd6, 8'h55);
                issue_a(1'b1, 8'd7, 8'h66);
            end
            begin
                issue_b(1'b0, 8'd6, 8'h00);
                issue_b(1'b0, 8'd7, 8'h00);
            end
        join
        repeat (3) @(negedge clk);
        chk("t3_n_grants", n_ord, 6);
        chk("t3_order", {26'd0, ord[5:0]}, 6'b010101);
        chk("t3_nreads", bq.size(), 3);
        if (bq.size() == 3) begin
            chk("t3_rd0", bq[0], 8'hAA);
            chk("t3_rd1", bq[1], 8'h55);
            chk("t3_rd2", bq[2], 8'h66);
        end
        chk("t3_b_rdata", b_rdata, 8'h66);

        // Only B, four back-to-back reads.
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        bq.delete();
        bgc.delete();
        for (int i = 0; i < 4; i++) begin
            issue_b(1'b0, 8'(i), 8'h00);
        end
        repeat (3) @(negedge clk);
        chk("t4_nreads", bq.size(), 4);
        if (bq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_rd", bq[i], 32'(16 + i));
            end
        end
        chk("t4_ngnt", bgc.size(), 4);
        if (bgc.size() == 4) begin
            chk("t4_span", bgc[3] - bgc[0], 9);
        end

        // Reset during RDWAIT of an A read.
        issue_a(1'b0, 8'd1, 8'h00);
        @(posedge clk);
        #2;
        reset = 1'b1;
        a_before = a_rv_n;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_ram_en", ram_en, 0);
        chk("t5_a_rvalid", a_rvalid, 0);
        chk("t5_a_rdata", a_rdata, 0);
        chk("t5_ram_addr", ram_addr, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_rvalid", a_rv_n, a_before);
        n_ord = 0;
        ord = '0;
        fork
            issue_a(1'b1, 8'd9, 8'h01);
            issue_b(1'b1, 8'd10, 8'h02);
        join
        @(negedge clk);
        chk("t5_n_grants", n_ord, 2);
        chk("t5_order", {30'd0, ord[1:0]}, 2'b01);

        // A drops its request while B holds the port.
        repeat (2) @(negedge clk);
        issue_b(1'b0, 8'd3, 8'h00);
        a_before = a_gnt_n;
        a_req = 1'b1;
        a_we = 1'b1;
        a_addr = 8'd3;
        a_wdata = 8'hFF;
        @(negedge clk);
        a_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_a_gnt", a_gnt_n, a_before);
        chk("t6_b_rdata", b_rdata, 8'h13);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
